iter_hspan: RTL and testbench
=============================

Name: iter_hspan

Overview:
Parametrised successor to the single-pixel horizontal line iterator. It walks a horizontal span [min(x0,x1), max(x0,x1)] on row y and emits LANES pixels per beat, with a per-lane valid mask. It clips the span to the screen and stalls on the output-enable backpressure. It sits between the shape rasteriser (triangle/polygon fill) and the framebuffer write port, which accepts LANES pixels per cycle.

Parameters:
CORDW, 9, coordinate width in bits (x and y).
LANES, 4, pixels emitted per beat; power of two, 1..16.
XMAX, 319, rightmost visible column; XMAX < 2**CORDW.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request a span; sampled only while idle
oe  in  1  output enable; a beat is consumed only when high
x0  in  CORDW  span endpoint 0
x1  in  CORDW  span endpoint 1
y  in  CORDW  row of the span
x  out  CORDW  column of lane 0 of the current beat
y_out  out  CORDW  latched row
mask  out  LANES  bit i set means pixel x+i is valid
drawing  out  1  current beat valid (DRAW state and oe)
busy  out  1  request in progress
done  out  1  one-cycle pulse when the span completes

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; x, y_out, mask = 0; drawing, busy, done = 0. Reset mid-span abandons the span with no done pulse.
- States: IDLE, DRAW. drawing is combinational: (state == DRAW) && oe.
- IDLE: done <= 0 unless set below. On start:
  - xl = min(x0,x1), xr = min(max(x0,x1), XMAX).
  - If min(x0,x1) > XMAX (fully clipped): stay IDLE, busy stays 0, done <= 1 next cycle, no beats.
  - Otherwise: x <= xl, y_out <= y, busy <= 1, state <= DRAW. The first beat is presented the next cycle.
- DRAW, oe=1: the beat is consumed.
  - If x+LANES-1 >= xr: state <= IDLE, busy <= 0, done <= 1.
  - Else x <= x+LANES.
- DRAW, oe=0: hold x, mask, state. drawing is 0.
- mask[i] = (x+i <= xr), evaluated for the current x. Lane 0 is the LSB.
- All x+i and x+LANES arithmetic is done at CORDW+1 bits, so there is no wrap at 2**CORDW. Spans ending at 2**CORDW-1 with XMAX at maximum must terminate correctly.
- start is ignored while busy.
- start in the cycle done is high (back-to-back) is accepted. done falls, and busy rises the next cycle.
- x0 == x1 gives a single beat with mask = 1.
- y_out is stable for the whole span.

Optional Feature:
ITER_HSPAN_ALIGN_EN
- Defined: the first beat starts at xl rounded down to a multiple of LANES. mask[i] additionally requires x+i >= xl, so leading lanes are masked off. This matches burst-aligned framebuffer writes. Beat count is ceil((xr - align(xl) + 1) / LANES).
- Undefined: x starts at xl exactly, and only trailing lanes can be masked.

Test Plan:
1. LANES=4, x0=10, x1=17, y=7, oe=1 -> beats (x=10, mask=1111), (x=14, mask=1111); done pulses 1 cycle after the last beat; y_out=7; busy high for 2 cycles.
2. x0=20, x1=14 (reversed) -> beats (x=14, 1111), (x=18, 0111); done next cycle.
3. x0=x1=5 -> one beat (x=5, mask=0001); start held high during done is accepted back-to-back with no idle gap beyond the done cycle.
4. x0=0, x1=11, oe toggling 1,0,0,1,0,1 -> x holds during oe=0 and drawing=0 in those cycles; exactly 3 consumed beats (x=0, 4, 8), then done.
5. Clipping, XMAX=319: x0=300, x1=400 -> 5 beats, last (x=316, mask=1111). x0=350, x1=400 -> no beats, busy=0, done pulses one cycle after start.
6. rst_n low mid-span at x=14 -> all outputs 0 immediately; no done; next start behaves normally. With ITER_HSPAN_ALIGN_EN, x0=10, x1=17 -> beats (x=8, 1100), (x=12, 1111), (x=16, 0011).

Source files
------------

// File: rtl/iter_hspan.sv
// Horizontal span iterator: walks [min(x0,x1), min(max(x0,x1),XMAX)] on row y, LANES pixels per beat.
// Define ITER_HSPAN_ALIGN_EN to start beats on LANES-aligned columns with leading lanes masked.

module iter_hspan_lane #(
    parameter int CORDW = 9,
    parameter int LANE  = 0,
    parameter bit ALIGN = 1'b0
) (
    input  logic [CORDW-1:0] x_i,
    input  logic [CORDW-1:0] xl_i,
    input  logic [CORDW-1:0] xr_i,
    input  logic             en_i,
    output logic             vld_o
);
    logic [CORDW:0] xi;

    // One extra bit so lanes past 2**CORDW-1 compare as out of range instead of wrapping.
    assign xi    = {1'b0, x_i} + (CORDW+1)'(LANE);
    assign vld_o = en_i && (xi <= {1'b0, xr_i}) && (!ALIGN || (xi >= {1'b0, xl_i}));
endmodule

module iter_hspan #(
    parameter int CORDW = 9,
    parameter int LANES = 4,
    parameter int XMAX  = 319
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             oe,
    input  logic [CORDW-1:0] x0,
    input  logic [CORDW-1:0] x1,
    input  logic [CORDW-1:0] y,
    output logic [CORDW-1:0] x,
    output logic [CORDW-1:0] y_out,
    output logic [LANES-1:0] mask,
    output logic             drawing,
    output logic             busy,
    output logic             done
);
`ifdef ITER_HSPAN_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam logic [CORDW-1:0] XMAX_C = CORDW'(XMAX);
    localparam logic [CORDW-1:0] LMASK  = CORDW'(LANES - 1);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t           state_q, state_d;
    logic [CORDW-1:0] x_q, x_d, xl_q, xl_d, xr_q, xr_d, y_q, y_d;
    logic             done_q, done_d;

    logic [CORDW-1:0] lo, hi, hi_clip, x_start;
    logic             clipped, last;

    assign lo      = (x0 <= x1) ? x0 : x1;
    assign hi      = (x0 <= x1) ? x1 : x0;
    assign hi_clip = (hi > XMAX_C) ? XMAX_C : hi;
    assign clipped = lo > XMAX_C;
    assign x_start = ALIGN ? (lo & ~LMASK) : lo;
    assign last    = ({1'b0, x_q} + (CORDW+1)'(LANES - 1)) >= {1'b0, xr_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            xl_q    <= '0;
            xr_q    <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            xl_q    <= xl_d;
            xr_q    <= xr_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        xl_d    = xl_q;
        xr_d    = xr_q;
        y_d     = y_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (clipped) begin
                    done_d = 1'b1;
                end else begin
                    state_d = DRAW;
                    x_d     = x_start;
                    xl_d    = lo;
                    xr_d    = hi_clip;
                    y_d     = y;
                end
            end
            DRAW: if (oe) begin
                if (last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    x_d = x_q + CORDW'(LANES);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == DRAW);
        drawing = busy && oe;
        done    = done_q;
        x       = x_q;
        y_out   = y_q;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        iter_hspan_lane #(.CORDW(CORDW), .LANE(i), .ALIGN(ALIGN)) u_lane (
            .x_i   (x_q),
            .xl_i  (xl_q),
            .xr_i  (xr_q),
            .en_i  (busy),
            .vld_o (mask[i])
        );
    end
endmodule

// File: tb/tb_iter_hspan.sv
// Scoreboard bench for iter_hspan: spans are expanded into expected beats by a plain arithmetic model.

module tb_iter_hspan;
    localparam int CORDW = 9;
    localparam int LANES = 4;
    localparam int XMAX  = 319;
`ifdef ITER_HSPAN_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             oe = 1'b1;
    logic [CORDW-1:0] x0 = '0, x1 = '0, y = '0;
    logic [CORDW-1:0] x, y_out;
    logic [LANES-1:0] mask;
    logic             drawing, busy, done;

    typedef struct {
        bit is_done;
        int bx;
        int bmask;
        int by;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   oe_rand = 1'b0;

    iter_hspan #(.CORDW(CORDW), .LANES(LANES), .XMAX(XMAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .oe(oe),
        .x0(x0), .x1(x1), .y(y),
        .x(x), .y_out(y_out), .mask(mask),
        .drawing(drawing), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected beats of one span, then its done marker.
    task automatic push_span(input int a, input int b, input int yy);
        int lo, hi, xr, xs, m;
        exp_t e;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        xr = (hi > XMAX) ? XMAX : hi;
        if (lo <= XMAX) begin
            xs = ALIGN ? (lo / LANES) * LANES : lo;
            for (int bx = xs; bx <= xr; bx += LANES) begin
                m = 0;
                for (int i = 0; i < LANES; i++)
                    if (bx + i <= xr && bx + i >= lo) m |= (1 << i);
                e.is_done = 1'b0; e.bx = bx; e.bmask = m; e.by = yy;
                exp_q.push_back(e);
            end
        end
        e.is_done = 1'b1; e.bx = 0; e.bmask = 0; e.by = 0;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        if (oe_rand) begin
            #1 oe = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("drawing_eq_busy_oe", int'(drawing), int'(busy && oe));
            if (drawing) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_not_done", int'(e.is_done), 0);
                    chk("beat_x", int'(x), e.bx);
                    chk("beat_mask", int'(mask), e.bmask);
                    chk("beat_y", int'(y_out), e.by);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_order", int'(e.is_done), 1);
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0 && !busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("span_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic do_span(input int a, input int b, input int yy);
        int lo;
        lo = (a < b) ? a : b;
        @(posedge clk); #2;
        x0 = CORDW'(a); x1 = CORDW'(b); y = CORDW'(yy); start = 1'b1;
        push_span(a, b, yy);
        @(posedge clk); #2;
        start = 1'b0;
        chk("busy_after_start", int'(busy), (lo <= XMAX) ? 1 : 0);
        if (lo > XMAX) chk("clipped_done", int'(done), 1);
        wait_idle();
    endtask

    initial begin
        bit seen;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_x", int'(x), 0);
        chk("rst_mask", int'(mask), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_y", int'(y_out), 0);
        rst_n = 1'b1;

        do_span(10, 17, 7);
        do_span(20, 14, 2);
        do_span(5, 5, 1);
        do_span(300, 400, 9);
        do_span(350, 400, 9);
        do_span(319, 319, 4);
        oe_rand = 1'b1;
        do_span(0, 11, 3);
        do_span(511, 0, 6);

        // Back-to-back: start held through a span (ignored while busy) and re-used at done.
        @(posedge clk); #2;
        x0 = 9'd5; x1 = 9'd5; y = 9'd8; start = 1'b1;
        push_span(5, 5, 8);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (done) begin seen = 1'b1; break; end
        end
        chk("b2b_done_seen", int'(seen), 1);
        x0 = 9'd30; x1 = 9'd37; y = 9'd11;
        push_span(30, 37, 11);
        @(posedge clk); #2;
        start = 1'b0;
        chk("b2b_busy", int'(busy), 1);
        wait_idle();

        // Reset mid-span abandons it without a done pulse.
        @(posedge clk); #2;
        x0 = 9'd10; x1 = 9'd60; y = 9'd3; start = 1'b1;
        push_span(10, 60, 3);
        @(posedge clk); #2;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_x", int'(x), 0);
        chk("midrst_mask", int'(mask), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_drawing", int'(drawing), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_y", int'(y_out), 0);
        exp_q.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #2;
            chk("midrst_no_done", int'(done), 0);
        end
        do_span(40, 47, 12);

        for (int n = 0; n < 40; n++)
            do_span($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
